// File: rtl/l1dcache_pkg.sv
// Shared types for the L1 data cache and its request-port arbiter.
package l1dcache_pkg;
  localparam int ADDR_W      = 30;
  localparam int OFFSET_BITS = 2;

  typedef logic [ADDR_W-1:0]             addr_t;
  typedef logic [3:0]                    mask_t;
  typedef logic [31:0]                   word_t;
  typedef logic [ADDR_W-OFFSET_BITS-1:0] line_t;

  typedef enum logic [0:0] {
    ISSUE     = 1'b0,
    ST_COMMIT = 1'b1
  } arb_state_e;

  function automatic line_t line_of(input addr_t a);
    return a[ADDR_W-1:OFFSET_BITS];
  endfunction

  // Counter width able to hold 0..max_val; never zero.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/l1dcache_core_if.sv
// Single request/response port of the L1 data cache array.
interface l1dcache_core_if;
  import l1dcache_pkg::*;

  logic  en;
  logic  enW;
  addr_t addr;
  mask_t mask;
  word_t reqData;
  logic  nAck;
  word_t respData;

  modport Client (output en, enW, addr, mask, reqData, input nAck, respData);
  modport Server (input en, enW, addr, mask, reqData, output nAck, respData);
endinterface

// File: rtl/l1dcache_sat_counter.sv
// Saturating counter: clear > load > increment (stops at MAX) > decrement (stops at 0).
module l1dcache_sat_counter
  import l1dcache_pkg::*;
#(
  parameter int MAX = 4,
  localparam int W  = cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      if (cnt_q < W'(MAX)) cnt_d = cnt_q + 1'b1;
    end else if (dec_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/l1dcache_port_arbiter.sv
// Shares the L1D request port between the load pipe and the store-queue drain,
// inserting the idle commit cycle every store write needs.
module l1dcache_port_arbiter
  import l1dcache_pkg::*;
#(
  parameter int ID_BITS     = 4,
  parameter int STARVE_MAX  = 4,
  parameter int RETRY_DELAY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  addr_t              ld_addr,
  input  logic [ID_BITS-1:0] ld_id,
  output logic               ld_resp_valid,
  output logic               ld_resp_hit,
  output word_t              ld_resp_data,
  output logic [ID_BITS-1:0] ld_resp_id,
  input  logic               st_valid,
  output logic               st_ready,
  input  addr_t              st_addr,
  input  mask_t              st_mask,
  input  word_t              st_data,
  output logic               st_done,
  output logic               st_miss,
  l1dcache_core_if.Client    cache
);
  localparam int SW = cnt_w(STARVE_MAX);
  localparam int BW = cnt_w(RETRY_DELAY);

  arb_state_e         state_q, state_d;
  logic               live_q;
  logic               ld_pend_q;
  logic [ID_BITS-1:0] ld_id_q;
  logic [SW-1:0]      starve_cnt;
  logic [BW-1:0]      backoff;
  logic               st_gnt, ld_gnt;
  logic               starved, bo_idle, commit;

  assign bo_idle = (backoff == '0);
  assign starved = (starve_cnt == SW'(STARVE_MAX));
  assign commit  = (state_q == ST_COMMIT) && !rst;

  // live_q holds off grants for the first cycle after reset.
  always_comb begin
    state_d = state_q;
    st_gnt  = 1'b0;
    ld_gnt  = 1'b0;
    case (state_q)
      ISSUE: begin
        if (live_q && !rst) begin
          if (st_valid && bo_idle && (starved || !ld_valid)) st_gnt = 1'b1;
          else if (ld_valid)                                 ld_gnt = 1'b1;
        end
        if (st_gnt) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ISSUE;
      default:   state_d = ISSUE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ISSUE;
      live_q    <= 1'b0;
      ld_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      ld_pend_q <= ld_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_gnt) ld_id_q <= ld_id;
  end

  l1dcache_sat_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (!st_valid || st_gnt),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (ld_gnt && st_valid && bo_idle),
    .dec_i      (1'b0),
    .cnt_o      (starve_cnt)
  );

  l1dcache_sat_counter #(.MAX(RETRY_DELAY)) u_backoff (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (1'b0),
    .load_i     (commit && cache.nAck),
    .load_val_i (BW'(RETRY_DELAY)),
    .inc_i      (1'b0),
    .dec_i      (1'b1),
    .cnt_o      (backoff)
  );

  assign ld_ready      = ld_gnt;
  assign st_ready      = st_gnt;
  assign cache.en      = ld_gnt || st_gnt;
  assign cache.enW     = st_gnt;
  assign cache.addr    = st_gnt ? st_addr : ld_addr;
  assign cache.mask    = st_gnt ? st_mask : '0;
  assign cache.reqData = st_gnt ? st_data : '0;

  // Responses belong to the request issued last cycle; reset drops them.
  assign ld_resp_valid = ld_pend_q && !rst;
  assign ld_resp_hit   = ld_resp_valid && !cache.nAck;
  assign ld_resp_data  = ld_resp_hit ? cache.respData : '0;
  assign ld_resp_id    = ld_resp_valid ? ld_id_q : '0;
  assign st_done       = commit && !cache.nAck;
  assign st_miss       = commit && cache.nAck;
endmodule
